// File: rtl/bit_serial_pkg.sv
// -----------------------------------------------------------------------------
// bit_serial_pkg
//
// Shared definitions for the bit-serial adder slice.
//   DEFAULT_WIDTH : default operand/result width used by bit_serial_adder
//   state_e       : FSM state encoding (IDLE=0, SHIFT=1, DONE=2)
// -----------------------------------------------------------------------------
package bit_serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bit_serial_adder_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//
// Purely combinational one-bit full-adder cell. The serial adder resolves every
// bit of the operation through this single cell.
//   a, b  : input  operand bits
//   c     : input  carry-in
//   sum   : output sum bit
//   carry : output carry-out
// -----------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/bit_serial_adder.sv
// -----------------------------------------------------------------------------
// bit_serial_adder
//
// Bit-serial WIDTH-bit adder. Operands and carry-in are captured on an accepted
// start pulse; one bit per clock is then resolved LSB first through a single
// full_adder cell. The result appears on sum/cout together with a one-cycle
// done pulse and is held until the next operation completes.
//
// Optional feature macro: BSA_SUB_MODE_EN
//   When defined, the sub port exists and sub=1 computes a - b - c (c acts as
//   borrow-in, cout as borrow-out). When undefined, the block is add-only.
//
// Ports
//   clk   : input  rising-edge clock
//   rst   : input  asynchronous active-high reset
//   start : input  request, sampled only in IDLE
//   a     : input  [WIDTH] augend / minuend
//   b     : input  [WIDTH] addend / subtrahend
//   c     : input  carry-in / borrow-in
//   sub   : input  subtract select (BSA_SUB_MODE_EN only)
//   busy  : output operation in progress, through the done cycle
//   done  : output one-cycle result-valid pulse
//   sum   : output [WIDTH] result register
//   cout  : output carry-out / borrow-out register
// -----------------------------------------------------------------------------
module bit_serial_adder
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
`ifdef BSA_SUB_MODE_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] bLoad;
  logic             cLoad;
  logic             coutFinal;
  logic             faSum;
  logic             faCarry;

  // Subtraction is a + ~b + ~c with the final carry inverted to give a borrow.
  // The captured sub bit is what drives the DONE-time inversion, so a change
  // on the sub pin mid-operation cannot corrupt the result.
`ifdef BSA_SUB_MODE_EN
  logic sub_q, sub_d;

  assign bLoad     = b ^ {WIDTH{sub}};
  assign cLoad     = c ^ sub;
  assign coutFinal = carry_q ^ sub_q;
`else
  assign bLoad     = b;
  assign cLoad     = c;
  assign coutFinal = carry_q;
`endif

  full_adder u_fullAdder (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c     (carry_q),
    .sum   (faSum),
    .carry (faCarry)
  );

  // busy stays high through the done pulse, which is registered and therefore
  // visible one cycle after the FSM has already returned to IDLE.
  assign busy = (state_q != IDLE) || done_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

  // Next-state and datapath: load in IDLE, shift one bit per cycle in SHIFT,
  // publish the result in DONE. The counter saturates at the last bit.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
`ifdef BSA_SUB_MODE_EN
    sub_d   = sub_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = bLoad;
          carry_d = cLoad;
          cnt_d   = '0;
`ifdef BSA_SUB_MODE_EN
          sub_d   = sub;
`endif
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        r_d     = {faSum, r_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = faCarry;
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        sum_d   = r_q;
        cout_d  = coutFinal;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation without a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BSA_SUB_MODE_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
`ifdef BSA_SUB_MODE_EN
      sub_q   <= sub_d;
`endif
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_adder
//
// Self-checking bench for bit_serial_adder (WIDTH=8). Expected {cout,sum}
// values are queued when a request is driven and popped when done pulses.
// Sub-mode vectors are included when BSA_SUB_MODE_EN is defined.
// -----------------------------------------------------------------------------
module tb_bit_serial_adder;

  localparam int WIDTH   = 8;
  localparam int LATENCY = WIDTH + 1;
  localparam int PERIOD  = WIDTH + 2;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic       s;
    logic [8:0] expRes;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
`ifdef BSA_SUB_MODE_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int         vecCount = 0;
  int         missCount = 0;
  int         cycleCnt = 0;
  int         startCycle = 0;
  logic [8:0] expQ[$];
  vec_t       vecs[$];

  bit_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c     (c),
`ifdef BSA_SUB_MODE_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter used to measure latency and throughput.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Last-resort guard so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, wanted finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  // Waits for done with a cycle budget; an expired budget counts as a failure.
  task automatic waitDone(input string name, output bit ok);
    int guard;
    guard = 0;
    while (done !== 1'b1 && guard < 4 * PERIOD) begin
      @(posedge clk);
      #1;
      guard++;
    end
    ok = (done === 1'b1);
    if (!ok) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL %s_timeout: got no done in %0d cycles, wanted done", name, guard);
    end
  endtask

  // Drives one request for a single cycle and queues its expected result.
  task automatic applyStimulus(input logic [7:0] aIn, input logic [7:0] bIn,
                               input logic cIn, input logic [8:0] expRes);
    @(negedge clk);
    a     = aIn;
    b     = bIn;
    c     = cIn;
    start = 1'b1;
    expQ.push_back(expRes);
    @(posedge clk);
    #1;
    startCycle = cycleCnt;
    start      = 1'b0;
    checkEq("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  // Waits for the result, checks latency and value, optionally the pulse tail.
  task automatic checkOutput(input string name, input bit checkTail);
    bit         ok;
    logic [8:0] expRes;
    waitDone(name, ok);
    if (expQ.size() == 0) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL %s_queue: got empty scoreboard, wanted an entry", name);
      return;
    end
    expRes = expQ.pop_front();
    if (!ok) return;
    checkEq({name, "_latency"}, cycleCnt - startCycle, LATENCY);
    checkEq({name, "_result"}, {23'd0, cout, sum}, {23'd0, expRes});
    if (checkTail) begin
      @(posedge clk);
      #1;
      checkEq({name, "_done_width"}, {31'd0, done}, 32'd0);
      checkEq({name, "_busy_fall"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    bit   ok;
    int   doneSeen;
    int   t1;
    int   t2;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    c     = 1'b0;
`ifdef BSA_SUB_MODE_EN
    sub   = 1'b0;
`endif
    $display("[TB] reset");
    repeat (2) @(negedge clk);
    checkEq("reset_busy", {31'd0, busy}, 32'd0);
    checkEq("reset_done", {31'd0, done}, 32'd0);
    checkEq("reset_sum", {24'd0, sum}, 32'd0);
    checkEq("reset_cout", {31'd0, cout}, 32'd0);
    rst = 1'b0;

    // Directed table of {a, b, c, sub, {cout,sum}}.
    vecs.push_back('{8'h3C, 8'h05, 1'b0, 1'b0, 9'h041});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 9'h100});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 9'h000});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 9'h100});
    vecs.push_back('{8'hAA, 8'h55, 1'b1, 1'b0, 9'h100});
    vecs.push_back('{8'h7F, 8'h01, 1'b1, 1'b0, 9'h081});
    vecs.push_back('{8'h00, 8'hFF, 1'b1, 1'b0, 9'h100});
`ifdef BSA_SUB_MODE_EN
    vecs.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 9'h1FE});
    vecs.push_back('{8'h09, 8'h03, 1'b1, 1'b1, 9'h005});
`endif
    // Random additions with an arithmetic reference.
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      vecs.push_back('{ra, rb, rc, 1'b0, {1'b0, ra} + {1'b0, rb} + {8'd0, rc}});
    end

    $display("[TB] table vectors");
    for (int i = 0; i < vecs.size(); i++) begin
`ifdef BSA_SUB_MODE_EN
      @(negedge clk);
      sub = vecs[i].s;
`endif
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].expRes);
      // Disturb the operand pins after acceptance; they must have no effect.
      a = ~vecs[i].a;
      b = ~vecs[i].b;
      c = ~vecs[i].c;
      checkOutput($sformatf("vec%0d", i), 1'b1);
    end
`ifdef BSA_SUB_MODE_EN
    @(negedge clk);
    sub = 1'b0;
`endif

    $display("[TB] start during SHIFT is ignored");
    applyStimulus(8'h10, 8'h20, 1'b0, 9'h030);
    repeat (3) @(negedge clk);
    a     = 8'hAA;
    b     = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("ignored", 1'b1);
    doneSeen = 0;
    repeat (2 * PERIOD) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) doneSeen++;
    end
    checkEq("ignored_extra_done", doneSeen, 0);

    $display("[TB] reset mid-operation");
    applyStimulus(8'h3C, 8'h05, 1'b0, 9'h041);
    checkOutput("prior", 1'b1);
    @(negedge clk);
    a     = 8'h77;
    b     = 8'h11;
    c     = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkEq("abort_sum", {24'd0, sum}, 32'd0);
    checkEq("abort_cout", {31'd0, cout}, 32'd0);
    checkEq("abort_busy", {31'd0, busy}, 32'd0);
    checkEq("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    doneSeen = 0;
    repeat (2 * PERIOD) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) doneSeen++;
    end
    checkEq("abort_no_done", doneSeen, 0);
    applyStimulus(8'h01, 8'h01, 1'b0, 9'h002);
    checkOutput("after_reset", 1'b1);

    $display("[TB] start held high");
    @(negedge clk);
    a     = 8'h12;
    b     = 8'h34;
    c     = 1'b0;
    start = 1'b1;
    waitDone("held_first", ok);
    t1 = cycleCnt;
    if (ok) checkEq("held_first_result", {23'd0, cout, sum}, 32'h046);
    @(posedge clk);
    #1;
    checkEq("held_done_width", {31'd0, done}, 32'd0);
    checkEq("held_busy_restart", {31'd0, busy}, 32'd1);
    waitDone("held_second", ok);
    t2 = cycleCnt;
    @(negedge clk);
    start = 1'b0;
    if (ok) checkEq("held_throughput", t2 - t1, PERIOD);
    @(posedge clk);
    #1;
    checkEq("held_busy_fall", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
